// File: rtl/afc_sar_band_search_pkg.sv
// Shared comparator codes, FSM state type and helpers for the AFC band search.
package afc_pkg;

  localparam logic [2:0] COMP_FAST   = 3'b100;
  localparam logic [2:0] COMP_SLOW   = 3'b010;
  localparam logic [2:0] COMP_FREEZE = 3'b001;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    REQ,
    WAIT,
    DECIDE,
    REFINE,
    DONE
  } afc_state_t;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == COMP_FAST) || (v == COMP_SLOW) || (v == COMP_FREEZE);
  endfunction

endpackage

// File: rtl/afc_sar_band_search_if.sv
// Comparator handshake and VCO band-control bundle for the AFC band search.
interface afc_sar_band_search_if #(
  parameter int unsigned BAND_W = 5
) ();

  logic              start;
  logic              meas_req;
  logic              meas_done;
  logic [2:0]        comp_in;
  logic [BAND_W-1:0] band_out;
  logic              band_chg;
  logic              busy;
  logic              locked;
  logic              err;

  modport master (
    input  start, meas_done, comp_in,
    output meas_req, band_out, band_chg, busy, locked, err
  );

  modport slave (
    output start, meas_done, comp_in,
    input  meas_req, band_out, band_chg, busy, locked, err
  );

endinterface

// File: rtl/afc_sar_band_search_settle_timer.sv
// Loadable down-counter that holds off the measurement request while the VCO settles.
module afc_settle_timer #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(SETTLE_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Loaded one below the cycle count so expiry lands on the last settle cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(SETTLE_CYC - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/afc_sar_band_search.sv
// Successive-approximation VCO band search, MSB first, with settle/request/retry sequencing.
// Optional +/-1 refinement after the LSB decision is enabled by defining AFC_REFINE_EN.
module afc_sar_band_search
  import afc_pkg::*;
#(
  parameter int unsigned BAND_W     = 5,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned RETRY_MAX  = 3,
  parameter int unsigned REFINE_MAX = 2
) (
  input logic                   clk,
  input logic                   rst,
  afc_sar_band_search_if.master bus
);

  localparam int unsigned KW      = (BAND_W > 1) ? $clog2(BAND_W) : 1;
  localparam int unsigned CNT_MAX = (RETRY_MAX > REFINE_MAX) ? RETRY_MAX : REFINE_MAX;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [BAND_W-1:0] MID_CODE = BAND_W'(1) << (BAND_W - 1);
  localparam logic [KW-1:0]     K_MSB    = KW'(BAND_W - 1);

  afc_state_t        state_q, state_d;
  logic [BAND_W-1:0] band_q, band_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CNT_W-1:0]  retry_q, retry_d;
  logic              busy_q, busy_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic              band_chg_q;
  logic [2:0]        comp_q;
  logic              tmr_load, tmr_expired;
`ifdef AFC_REFINE_EN
  logic              refine_q, refine_d;
  logic              up_q, up_d, up;
  logic [CNT_W-1:0]  steps_q, steps_d;
`endif

  afc_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .en_i      (state_q == SETTLE),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    band_d   = band_q;
    k_d      = k_q;
    retry_d  = retry_q;
    busy_d   = busy_q;
    locked_d = locked_q;
    err_d    = err_q;
    tmr_load = 1'b0;
`ifdef AFC_REFINE_EN
    refine_d = refine_q;
    up_d     = up_q;
    steps_d  = steps_q;
    up       = (comp_q == COMP_SLOW);
`endif
    case (state_q)
      // DONE behaves as IDLE so a new start is accepted in the completion cycle.
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          band_d   = MID_CODE;
          k_d      = K_MSB;
          retry_d  = '0;
          locked_d = 1'b0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = SETTLE;
`ifdef AFC_REFINE_EN
          refine_d = 1'b0;
          steps_d  = '0;
`endif
        end
      end
      SETTLE: if (tmr_expired) state_d = REQ;
      REQ:    state_d = WAIT;
      WAIT: begin
        if (bus.meas_done) begin
`ifdef AFC_REFINE_EN
          state_d = refine_q ? REFINE : DECIDE;
`else
          state_d = DECIDE;
`endif
        end
      end
      DECIDE, REFINE: begin
        if (!is_onehot3(comp_q)) begin
          // Invalid codes re-request the same band without re-settling.
          retry_d = retry_q + 1'b1;
          if (retry_d == CNT_W'(RETRY_MAX)) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end else begin
          retry_d = '0;
          if (comp_q == COMP_FREEZE) begin
            busy_d   = 1'b0;
            locked_d = 1'b1;
            state_d  = DONE;
          end else if (state_q == DECIDE) begin
            if (comp_q == COMP_FAST) band_d[k_q] = 1'b0;
            if (k_q != '0) begin
              band_d[k_q - 1'b1] = 1'b1;
              k_d      = k_q - 1'b1;
              tmr_load = 1'b1;
              state_d  = SETTLE;
            end else begin
`ifdef AFC_REFINE_EN
              refine_d = 1'b1;
              tmr_load = 1'b1;
              state_d  = SETTLE;
`else
              busy_d   = 1'b0;
              locked_d = 1'b1;
              state_d  = DONE;
`endif
            end
          end
`ifdef AFC_REFINE_EN
          else begin
            // A reversal steps back to the previous code and stops; saturation stops in place.
            if ((steps_q != '0) && (up != up_q)) begin
              band_d   = up ? band_q + 1'b1 : band_q - 1'b1;
              busy_d   = 1'b0;
              locked_d = 1'b1;
              state_d  = DONE;
            end else if (up ? (band_q == '1) : (band_q == '0)) begin
              busy_d   = 1'b0;
              locked_d = 1'b1;
              state_d  = DONE;
            end else begin
              band_d  = up ? band_q + 1'b1 : band_q - 1'b1;
              up_d    = up;
              steps_d = steps_q + 1'b1;
              if (steps_d == CNT_W'(REFINE_MAX)) begin
                busy_d   = 1'b0;
                locked_d = 1'b1;
                state_d  = DONE;
              end else begin
                tmr_load = 1'b1;
                state_d  = SETTLE;
              end
            end
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      band_q     <= MID_CODE;
      k_q        <= K_MSB;
      retry_q    <= '0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      band_chg_q <= 1'b0;
`ifdef AFC_REFINE_EN
      refine_q   <= 1'b0;
      up_q       <= 1'b0;
      steps_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      band_q     <= band_d;
      k_q        <= k_d;
      retry_q    <= retry_d;
      busy_q     <= busy_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      band_chg_q <= (band_d != band_q);
`ifdef AFC_REFINE_EN
      refine_q   <= refine_d;
      up_q       <= up_d;
      steps_q    <= steps_d;
`endif
    end
  end

  // Comparator result is captured only while waiting for it.
  always_ff @(posedge clk) begin
    if ((state_q == WAIT) && bus.meas_done) comp_q <= bus.comp_in;
  end

  assign bus.meas_req = (state_q == REQ);
  assign bus.band_out = band_q;
  assign bus.band_chg = band_chg_q;
  assign bus.busy     = busy_q;
  assign bus.locked   = locked_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_afc_sar_band_search.sv
// Bench for afc_sar_band_search: scripted comparator vectors, corner sequences, random targets.
module tb_afc_sar_band_search;
  import afc_pkg::*;

  localparam int W = 5;
  localparam logic [2:0] S = 3'b010, F = 3'b100, Z = 3'b001, N = 3'b000, B = 3'b011;

  typedef struct {
    logic [23:0] codes;
    logic [39:0] trials;
    int          n;
    int          fin;
    bit          lk;
    bit          er;
    bit          xstart;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  afc_sar_band_search_if #(.BAND_W(W)) ifc ();

  afc_sar_band_search #(
    .BAND_W(W), .SETTLE_CYC(4), .RETRY_MAX(3), .REFINE_MAX(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Comparator model and observation queues
  logic [2:0] code_q[$];
  logic [2:0] used_q[$];
  int         trial_q[$];
  int         req_cyc[$];
  int         done_cyc[$];
  int         exp_tr[$];
  bit         tgt_mode = 1'b0;
  bit         frz_en = 1'b0;
  int         tgt = 0;
  int         chg_err = 0;

  initial begin
    logic [2:0] code;
    int         d;
    bit         have;
    ifc.start     = 1'b0;
    ifc.meas_done = 1'b0;
    ifc.comp_in   = 3'b000;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && ifc.meas_req === 1'b1) begin
        trial_q.push_back(int'(ifc.band_out));
        req_cyc.push_back(cyc);
        have = 1'b1;
        code = N;
        d    = 2;
        if (tgt_mode) begin
          if (frz_en && int'(ifc.band_out) == tgt) code = Z;
          else if (int'(ifc.band_out) <= tgt)      code = S;
          else                                     code = F;
          d = int'($urandom_range(1, 4));
        end else if (code_q.size() == 0) begin
          have = 1'b0;
        end else begin
          code = code_q.pop_front();
        end
        if (have) begin
          used_q.push_back(code);
          repeat (d) @(posedge clk);
          #1;
          ifc.meas_done = 1'b1;
          ifc.comp_in   = code;
          done_cyc.push_back(cyc);
          @(posedge clk);
          #1;
          ifc.meas_done = 1'b0;
          ifc.comp_in   = 3'b000;
        end
      end
    end
  end

  // band_chg must be high exactly in cycles where band_out shows a new value
  initial begin
    int prev;
    prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = int'(ifc.band_out);
      end else begin
        if ((int'(ifc.band_out) != prev) != (ifc.band_chg === 1'b1)) chg_err++;
        prev = int'(ifc.band_out);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [23:0] c, logic [39:0] t, int n, int fin, bit lk, bit er, bit xs);
    vec_t v;
    v.codes = c; v.trials = t; v.n = n; v.fin = fin; v.lk = lk; v.er = er; v.xstart = xs;
    return v;
  endfunction

  task automatic run_search(string tag, int exp_fin, bit exp_lk, bit exp_er, bit xstart);
    int s, fall, gap;
    trial_q.delete(); req_cyc.delete(); done_cyc.delete(); used_q.delete();
    chg_err = 0;
    @(posedge clk); #1;
    ifc.start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    if (xstart) begin
      repeat (2) @(posedge clk);
      #1 ifc.start = 1'b1;
      @(posedge clk);
      #1 ifc.start = 1'b0;
    end
    fall = -1;
    for (int i = 0; i < 3000 && fall < 0; i++) begin
      @(negedge clk);
      if (ifc.busy === 1'b0) fall = cyc;
    end
    if (fall < 0) begin
      check({tag, "_timeout"}, 1, 0);
      return;
    end
    @(posedge clk); #1;
    check({tag, "_band"},   int'(ifc.band_out), exp_fin);
    check({tag, "_locked"}, int'(ifc.locked), int'(exp_lk));
    check({tag, "_err"},    int'(ifc.err), int'(exp_er));
    check({tag, "_busy"},   int'(ifc.busy), 0);
    check({tag, "_nreq"},   trial_q.size(), exp_tr.size());
    for (int i = 0; i < exp_tr.size() && i < trial_q.size(); i++)
      check($sformatf("%s_trial%0d", tag, i), trial_q[i], exp_tr[i]);
    if (req_cyc.size() > 0) check({tag, "_req0_lat"}, req_cyc[0] - s, 5);
    for (int i = 1; i < req_cyc.size() && i <= used_q.size() && i <= done_cyc.size(); i++) begin
      gap = ($countones(used_q[i-1]) == 1) ? 6 : 2;
      check($sformatf("%s_req%0d_lat", tag, i), req_cyc[i] - done_cyc[i-1], gap);
    end
    if (done_cyc.size() > 0) check({tag, "_busy_fall"}, fall - done_cyc[done_cyc.size()-1], 2);
    check({tag, "_band_chg"}, chg_err, 0);
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = mk({S, F, F, S, S, 9'd0}, {5'd16, 5'd24, 5'd20, 5'd18, 5'd19, 15'd0}, 5, 19, 1, 0, 1);
    vt[1] = mk({F, F, F, F, F, 9'd0}, {5'd16, 5'd8, 5'd4, 5'd2, 5'd1, 15'd0}, 5, 0, 1, 0, 0);
    vt[2] = mk({S, S, S, S, S, 9'd0}, {5'd16, 5'd24, 5'd28, 5'd30, 5'd31, 15'd0}, 5, 31, 1, 0, 0);
    vt[3] = mk({S, Z, 18'd0}, {5'd16, 5'd24, 30'd0}, 2, 24, 1, 0, 0);
    vt[4] = mk({N, N, N, 15'd0}, {5'd16, 5'd16, 5'd16, 25'd0}, 3, 16, 0, 1, 0);
    vt[5] = mk({B, S, N, N, F, S, S, S},
               {5'd16, 5'd16, 5'd24, 5'd24, 5'd24, 5'd20, 5'd22, 5'd23}, 8, 23, 1, 0, 0);
    vt[6] = mk({Z, 21'd0}, {5'd16, 35'd0}, 1, 16, 1, 0, 0);
    vt[7] = mk({F, S, F, S, F, 9'd0}, {5'd16, 5'd8, 5'd12, 5'd10, 5'd11, 15'd0}, 5, 10, 1, 0, 0);
    vt[8] = mk({3'b110, 3'b111, F, F, F, F, F, 3'd0},
               {5'd16, 5'd16, 5'd16, 5'd8, 5'd4, 5'd2, 5'd1, 5'd0}, 7, 0, 1, 0, 0);

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_band",     int'(ifc.band_out), 16);
    check("rst_busy",     int'(ifc.busy), 0);
    check("rst_locked",   int'(ifc.locked), 0);
    check("rst_err",      int'(ifc.err), 0);
    check("rst_meas_req", int'(ifc.meas_req), 0);
    check("rst_band_chg", int'(ifc.band_chg), 0);
    @(negedge clk);
    rst = 1'b0;

    // Scripted comparator vectors
    tgt_mode = 1'b0;
    for (int v = 0; v < 9; v++) begin
      code_q.delete();
      exp_tr.delete();
      for (int i = 0; i < vt[v].n; i++) begin
        code_q.push_back(vt[v].codes[23 - 3*i -: 3]);
        exp_tr.push_back(int'(vt[v].trials[39 - 5*i -: 5]));
      end
      run_search($sformatf("vec%0d", v), vt[v].fin, vt[v].lk, vt[v].er, vt[v].xstart);
    end

    // Reset while waiting on the second trial's comparator result
    begin
      int seen;
      code_q.delete();
      code_q.push_back(S);
      trial_q.delete(); req_cyc.delete(); done_cyc.delete(); used_q.delete();
      @(posedge clk); #1 ifc.start = 1'b1;
      @(posedge clk); #1 ifc.start = 1'b0;
      seen = 0;
      for (int i = 0; i < 200 && seen == 0; i++) begin
        @(negedge clk);
        if (trial_q.size() >= 2) seen = 1;
      end
      check("midrst_reached_wait", seen, 1);
      @(posedge clk); #1;
      check("midrst_pre_band", int'(ifc.band_out), 24);
      rst = 1'b1;
      #1;
      check("midrst_band",     int'(ifc.band_out), 16);
      check("midrst_busy",     int'(ifc.busy), 0);
      check("midrst_meas_req", int'(ifc.meas_req), 0);
      @(posedge clk); #1;
      check("midrst_meas_req_next", int'(ifc.meas_req), 0);
      @(negedge clk);
      rst = 1'b0;
    end

    // Random targets against an arithmetic SAR model
    tgt_mode = 1'b1;
    for (int r = 0; r < 20; r++) begin
      tgt    = int'($urandom_range(0, 31));
      frz_en = 1'($urandom_range(0, 1));
      exp_tr.delete();
      for (int i = 0; i < W; i++) begin
        int tr;
        tr = ((tgt >> (W - i)) << (W - i)) | (1 << (W - 1 - i));
        exp_tr.push_back(tr);
        if (frz_en && tr == tgt) break;
      end
      run_search($sformatf("rnd%0d_t%0d_f%0d", r, tgt, frz_en), tgt, 1'b1, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
